// File: rtl/fram_port_arbiter.sv
// Port-B arbiter for the banked feature SRAM: decoder reads share the banks with
// CU writebacks, which are buffered in a small FIFO and drained around the reads.
module fram_port_arbiter #(
    parameter int ADDR_WIDTH      = 12,
    parameter int DATA_WIDTH      = 32,
    parameter int BANK_NUM        = 4,
    parameter int BANK_ADDR_WIDTH = ADDR_WIDTH - $clog2(BANK_NUM),
    parameter int WFIFO_DEPTH     = 4,
    parameter int MAX_WAIT        = 8
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                rd_req,
    input  logic [ADDR_WIDTH-1:0]               rd_addr,
    output logic                                rd_gnt,
    output logic                                rd_rvalid,
    output logic [DATA_WIDTH-1:0]               rd_rdata,
    input  logic                                wr_valid,
    input  logic [ADDR_WIDTH-1:0]               wr_addr,
    input  logic [DATA_WIDTH-1:0]               wr_data,
    output logic                                wr_ready,
    input  logic                                clr_stats,
    output logic [BANK_NUM*BANK_ADDR_WIDTH-1:0] bram_addr,
    output logic [BANK_NUM*DATA_WIDTH-1:0]      bram_wdata,
    output logic [BANK_NUM-1:0]                 bram_we,
    output logic [BANK_NUM-1:0]                 bram_en,
    input  logic [BANK_NUM*DATA_WIDTH-1:0]      bram_rdata,
    output logic                                idle,
    output logic [15:0]                         conflict_cnt
);
    localparam int BANK_W = $clog2(BANK_NUM);
    localparam int PTR_W  = $clog2(WFIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int WAIT_W = $clog2(MAX_WAIT + 1);

    logic [ADDR_WIDTH-1:0] fifo_addr [WFIFO_DEPTH];
    logic [DATA_WIDTH-1:0] fifo_data [WFIFO_DEPTH];
    logic [PTR_W-1:0]      head_ptr, tail_ptr, offset;
    logic [CNT_W-1:0]      count, count_next;
    logic [WAIT_W-1:0]     wait_cnt;
    logic [BANK_W-1:0]     rd_bank, wr_bank, rd_bank_q;
    logic [ADDR_WIDTH-1:0] head_addr;
    logic [DATA_WIDTH-1:0] head_data, rdata_hold;
    logic                  fifo_empty, hazard, conflict, urgent;
    logic                  issue_rd, issue_wr, push;

    assign head_addr  = fifo_addr[head_ptr];
    assign head_data  = fifo_data[head_ptr];
    assign fifo_empty = (count == '0);
    assign rd_bank    = rd_addr[BANK_W-1:0];
    assign wr_bank    = head_addr[BANK_W-1:0];
    assign push       = wr_valid && wr_ready;
    assign count_next = count + CNT_W'(push) - CNT_W'(issue_wr);
    assign rd_gnt     = issue_rd;

    // A read may not pass any queued write to the same word, not just the head.
    always_comb begin
        hazard = 1'b0;
        offset = '0;
        for (int i = 0; i < WFIFO_DEPTH; i++) begin
            offset = PTR_W'(i) - head_ptr;
            if (({1'b0, offset} < count) && (fifo_addr[i] == rd_addr)) begin
                hazard = 1'b1;
            end
        end
        hazard = hazard && rd_req;
    end

    always_comb begin
        conflict = rd_req && !fifo_empty && (rd_bank == wr_bank);
        urgent   = (count == CNT_W'(WFIFO_DEPTH)) || (wait_cnt == WAIT_W'(MAX_WAIT));
        issue_wr = rst_n && !fifo_empty && (hazard || urgent || !conflict);
        issue_rd = rst_n && rd_req && !hazard && !(conflict && urgent);
    end

    always_comb begin
        bram_en    = '0;
        bram_we    = '0;
        bram_addr  = '0;
        bram_wdata = '0;
        if (issue_wr) begin
            bram_en[wr_bank] = 1'b1;
            bram_we[wr_bank] = 1'b1;
            bram_addr[wr_bank*BANK_ADDR_WIDTH +: BANK_ADDR_WIDTH] = head_addr[ADDR_WIDTH-1:BANK_W];
            bram_wdata[wr_bank*DATA_WIDTH +: DATA_WIDTH]          = head_data;
        end
        if (issue_rd) begin
            bram_en[rd_bank] = 1'b1;
            bram_addr[rd_bank*BANK_ADDR_WIDTH +: BANK_ADDR_WIDTH] = rd_addr[ADDR_WIDTH-1:BANK_W];
        end
    end

    assign rd_rdata = rd_rvalid ? bram_rdata[rd_bank_q*DATA_WIDTH +: DATA_WIDTH] : rdata_hold;

    // Entry storage needs no reset; validity comes from head/count.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_addr[tail_ptr] <= wr_addr;
            fifo_data[tail_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_ptr <= '0;
            tail_ptr <= '0;
            count    <= '0;
            wait_cnt <= '0;
            wr_ready <= 1'b0;
            idle     <= 1'b1;
        end else begin
            if (push) tail_ptr <= tail_ptr + 1'b1;
            if (issue_wr) head_ptr <= head_ptr + 1'b1;
            count <= count_next;
            if (issue_wr || fifo_empty) begin
                wait_cnt <= '0;
            end else if (wait_cnt != WAIT_W'(MAX_WAIT)) begin
                wait_cnt <= wait_cnt + 1'b1;
            end
            wr_ready <= (count_next < CNT_W'(WFIFO_DEPTH));
            idle     <= (count_next == '0) && !issue_rd;
        end
    end

    // Read return path; rd_rdata keeps the last returned word between reads.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_rvalid    <= 1'b0;
            rd_bank_q    <= '0;
            rdata_hold   <= '0;
            conflict_cnt <= '0;
        end else begin
            rd_rvalid <= issue_rd;
            if (issue_rd) rd_bank_q <= rd_bank;
            if (rd_rvalid) rdata_hold <= rd_rdata;
            if (clr_stats) begin
                conflict_cnt <= '0;
            end else if ((hazard || conflict) && (conflict_cnt != 16'hFFFF)) begin
                conflict_cnt <= conflict_cnt + 16'd1;
            end
        end
    end
endmodule

// File: doc/fram_port_arbiter.md
Name: fram_port_arbiter

Overview:
Arbitrates feature-SRAM port B between the decoder's operand-read stream and the CU's result writeback stream. It replaces the fatal bank-conflict exception with a buffered, starvation-free schedule. Writebacks enter a small write FIFO and are drained to banks not being read. Reads take priority, except on read-after-write hazards or when a write has waited too long. The block sits between the decoder/CU and the per-bank port-B pins of the feature BRAM array.

Parameters:
ADDR_WIDTH, 12, word address width of the unified feature SRAM
DATA_WIDTH, 32, data word width
BANK_NUM, 4, number of banks; power of two, >=2
BANK_ADDR_WIDTH, ADDR_WIDTH-$clog2(BANK_NUM), per-bank word address width
WFIFO_DEPTH, 4, write FIFO entries; power of two, >=2
MAX_WAIT, 8, cycles a FIFO head may be deferred before it is forced

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
rd_req  in  1  decoder read request (level, held until granted)
rd_addr  in  ADDR_WIDTH  read word address
rd_gnt  out  1  read issued to a bank this cycle
rd_rvalid  out  1  read data valid; exactly 1 cycle after rd_gnt
rd_rdata  out  DATA_WIDTH  read data
wr_valid  in  1  writeback valid
wr_addr  in  ADDR_WIDTH  writeback word address
wr_data  in  DATA_WIDTH  writeback data
wr_ready  out  1  FIFO can accept a writeback
clr_stats  in  1  synchronous clear of conflict_cnt
bram_addr  out  BANK_NUM*BANK_ADDR_WIDTH  per-bank address, bank i at [i*BANK_ADDR_WIDTH +: BANK_ADDR_WIDTH]
bram_wdata  out  BANK_NUM*DATA_WIDTH  per-bank write data
bram_we  out  BANK_NUM  per-bank write enable
bram_en  out  BANK_NUM  per-bank enable
bram_rdata  in  BANK_NUM*DATA_WIDTH  per-bank read data, 1-cycle latency
idle  out  1  FIFO empty and no read in flight
conflict_cnt  out  16  saturating count of conflict/hazard cycles

Behaviour:
- Reset (async, rst_n low): FIFO empty, wait_cnt=0, conflict_cnt=0, rd_rvalid=0, rd_rdata=0, wr_ready=0, idle=1. rd_gnt, bram_en and bram_we are forced to 0 while rst_n is low.
- Bank mapping is low-order interleave: bank = addr[$clog2(BANK_NUM)-1:0]; bank address = addr[ADDR_WIDTH-1:$clog2(BANK_NUM)].
- wr_ready is registered: next value = (next FIFO count < WFIFO_DEPTH). It rises the first clk after reset release.
- Push occurs when wr_valid && wr_ready. A full FIFO never accepts a push, even in a cycle where it pops.
- Per-cycle decision is combinational from FIFO state and rd_req:
  - H (hazard): rd_req and rd_addr equals the address of any valid FIFO entry.
  - C (conflict): rd_req, FIFO non-empty, and bank(rd_addr)==bank(head).
  - U (urgent): count==WFIFO_DEPTH or wait_cnt==MAX_WAIT.
- Resulting issue:
  - H: rd_gnt=0; issue head write.
  - C and U: issue head write; rd_gnt=0.
  - C and not U: rd_gnt=1; head write deferred.
  - Otherwise: read (if rd_req) and head write (if any) both issue, on different banks in the same cycle.
- Issued write: bram_en[b]=bram_we[b]=1 with head address/data; FIFO pops.
- Issued read: bram_en[b]=1, bram_we[b]=0. The bank index is registered; next cycle rd_rvalid=1 and rd_rdata = that bank's bram_rdata. rd_rdata holds its value when rd_rvalid=0.
- Unused bram_addr/bram_wdata lanes are don't-care; en/we for those lanes are 0.
- A write accepted in cycle t is issuable no earlier than t+1; there is no same-cycle bypass.
- wait_cnt: 0 when FIFO empty or on pop. Otherwise +1 per deferred cycle, saturating at MAX_WAIT.
- conflict_cnt: +1 in any cycle where H or C holds; saturates at 16'hFFFF. clr_stats zeroes it next cycle and takes priority over increment.
- idle = FIFO empty && !rd_rvalid, registered.
- Writes complete in FIFO order. A read never returns data older than an accepted write to the same address.

Test Plan:
- Reset, then idle: wr_ready=0 during reset, 1 one cycle after release; all bram_en=0; idle=1; conflict_cnt=0.
- Read 0x005 alone: rd_gnt=1 on cycle t with bram_en=4'b0010 and bram_addr lane1=0x001; rd_rvalid=1 at t+1 with lane-1 rdata.
- Write 0x004 (bank0) pending, continuous reads to 0x001 (bank1): both issue in the same cycle; conflict_cnt stays 0.
- Write 0x008 (bank0) pending, continuous reads to bank 0 at 0x000/0x004: reads win for 8 cycles, write forced on cycle 9 with rd_gnt=0 there; conflict_cnt=9.
- Write 0x010 accepted, read 0x010 next cycle: rd_gnt=0 and write issued; rd_gnt=1 the following cycle; rd_rdata equals the written data.
- Four writes to bank 2 with bank-2 reads held: wr_ready=0 after the 4th; next cycle is urgent, write issues and rd_gnt=0; wr_ready returns to 1.
